// File: rtl/stopwatch_counter_pkg.sv
// Shared definitions for the stopwatch core: blank digit code, run/pause
// state encoding, adjust field select codes and the mod-60 BCD increment
// used by both the seconds and minutes fields.
package stopwatch_counter_pkg;

  localparam logic [3:0] BLANK = 4'hF;

  typedef enum logic {
    ST_PAUSED = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  typedef enum logic {
    SEL_SEC = 1'b0,
    SEL_MIN = 1'b1
  } sel_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd60_t;

  typedef struct packed {
    logic   wrap;
    bcd60_t val;
  } bcd60_inc_t;

  // Next value of a 00..59 BCD field; wrap is set on 59 -> 00.
  function automatic bcd60_inc_t bcd60_inc(input logic [3:0] tens, input logic [3:0] ones);
    bcd60_inc_t r;
    r.wrap     = 1'b0;
    r.val.tens = tens;
    r.val.ones = ones;
    if (ones != 4'd9) begin
      r.val.ones = ones + 4'd1;
    end else begin
      r.val.ones = '0;
      if (tens != 4'd5) begin
        r.val.tens = tens + 4'd1;
      end else begin
        r.val.tens = '0;
        r.wrap     = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_counter_tick_divider.sv
// tick_divider: modulo-DIV cycle counter.
//  CLK, RESET : clock, synchronous active-high reset
//  en         : advance the count (frozen when low)
//  clr        : force count to 0 (overrides en)
//  tick       : 1-cycle pulse in the enabled cycle at terminal count DIV-1
module tick_divider #(
  parameter int unsigned DIV = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] TERM = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == TERM) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: MM:SS BCD time-keeping core feeding the 7-segment mux.
//  CLK, RESET : clock, synchronous active-high reset
//  PAUSE      : 1-cycle pulse, toggles run/paused (also while adjusting)
//  ADJ        : level, adjust mode (stops counting, increments selected field)
//  SEL        : level, adjust field: 0 = seconds, 1 = minutes
//  d0..d3     : registered digit codes ss ones, ss tens, mm ones, mm tens
//               (4'hF = blank while the selected field blinks)
//  RUNNING    : registered, 1 when in run state
module stopwatch_counter
  import stopwatch_counter_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned RUN_DIV   = CLK_HZ,
  parameter int unsigned ADJ_DIV   = CLK_HZ / 2,
  parameter int unsigned BLINK_DIV = CLK_HZ / 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       PAUSE,
  input  logic       ADJ,
  input  logic       SEL,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic       RUNNING
);

  state_t     state_q, state_d;
  logic       running_q, running_d;
  logic       blink_phase_q, blink_phase_d;
  bcd60_t     ss_q, ss_d, mm_q, mm_d;
  logic [3:0] d0_q, d0_d, d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;

  logic       run_en, run_tick, adj_tick, blink_tick;
  bcd60_t     ss_next, mm_next;
  logic       ss_wrap, mm_wrap_unused;
  logic       blank_sec, blank_min;

  // ADJ gates the run divider combinationally, so a tick coinciding with
  // ADJ rising is dropped and the partial second is preserved.
  assign run_en = (state_q == ST_RUN) && !ADJ;

  tick_divider #(.DIV(RUN_DIV)) u_run_div (
    .CLK(CLK), .RESET(RESET), .en(run_en), .clr(1'b0), .tick(run_tick)
  );

  tick_divider #(.DIV(ADJ_DIV)) u_adj_div (
    .CLK(CLK), .RESET(RESET), .en(ADJ), .clr(!ADJ), .tick(adj_tick)
  );

  tick_divider #(.DIV(BLINK_DIV)) u_blink_div (
    .CLK(CLK), .RESET(RESET), .en(1'b1), .clr(1'b0), .tick(blink_tick)
  );

  always_comb begin
    state_d = state_q;
    if (PAUSE) state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
    running_d     = (state_d == ST_RUN);
    blink_phase_d = blink_phase_q ^ blink_tick;

    {ss_wrap, ss_next}        = bcd60_inc(ss_q.tens, ss_q.ones);
    {mm_wrap_unused, mm_next} = bcd60_inc(mm_q.tens, mm_q.ones);

    ss_d = ss_q;
    mm_d = mm_q;
    if (run_tick) begin
      ss_d = ss_next;
      if (ss_wrap) mm_d = mm_next;
    end else if (adj_tick) begin
      if (SEL == SEL_MIN) mm_d = mm_next;
      else                ss_d = ss_next;
    end

    blank_sec = ADJ && blink_phase_q && (SEL == SEL_SEC);
    blank_min = ADJ && blink_phase_q && (SEL == SEL_MIN);
    d0_d = blank_sec ? BLANK : ss_q.ones;
    d1_d = blank_sec ? BLANK : ss_q.tens;
    d2_d = blank_min ? BLANK : mm_q.ones;
    d3_d = blank_min ? BLANK : mm_q.tens;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= ST_PAUSED;
      running_q     <= 1'b0;
      blink_phase_q <= 1'b0;
      ss_q          <= '0;
      mm_q          <= '0;
      d0_q          <= '0;
      d1_q          <= '0;
      d2_q          <= '0;
      d3_q          <= '0;
    end else begin
      state_q       <= state_d;
      running_q     <= running_d;
      blink_phase_q <= blink_phase_d;
      ss_q          <= ss_d;
      mm_q          <= mm_d;
      d0_q          <= d0_d;
      d1_q          <= d1_d;
      d2_q          <= d2_d;
      d3_q          <= d3_d;
    end
  end

  assign d0      = d0_q;
  assign d1      = d1_q;
  assign d2      = d2_q;
  assign d3      = d3_q;
  assign RUNNING = running_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter with reduced dividers
// (RUN_DIV=8, ADJ_DIV=4, BLINK_DIV=2). Expected output words
// {d3,d2,d1,d0,RUNNING} are queued and compared when due.
module tb_stopwatch_counter;

  localparam int unsigned ADJ_DIV_TB = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       PAUSE = 1'b0;
  logic       ADJ = 1'b0;
  logic       SEL = 1'b0;
  logic [3:0] d0, d1, d2, d3;
  logic       RUNNING;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned since_rst = 0;
  logic [16:0] sb[$];
  logic [16:0] exp_w;
  logic [16:0] obs;

  stopwatch_counter #(
    .CLK_HZ(8), .RUN_DIV(8), .ADJ_DIV(4), .BLINK_DIV(2)
  ) dut (
    .CLK(CLK), .RESET(RESET), .PAUSE(PAUSE), .ADJ(ADJ), .SEL(SEL),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .RUNNING(RUNNING)
  );

  always #5 CLK = ~CLK;

  assign obs = {d3, d2, d1, d0, RUNNING};

  // Clock edges since the last edge that saw RESET high (blink phase reference).
  always @(posedge CLK) begin
    if (RESET) since_rst <= 0;
    else       since_rst <= since_rst + 1;
  end

  function automatic logic [16:0] mk(input int unsigned a3, input int unsigned a2,
                                     input int unsigned a1, input int unsigned a0,
                                     input logic r);
    logic [3:0] v3, v2, v1, v0;
    v3 = a3[3:0]; v2 = a2[3:0]; v1 = a1[3:0]; v0 = a0[3:0];
    return {v3, v2, v1, v0, r};
  endfunction

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1; PAUSE = 1'b0; ADJ = 1'b0; SEL = 1'b0;
    cyc(2);
    RESET = 1'b0;
  endtask

  task automatic pulse_pause();
    PAUSE = 1'b1;
    cyc(1);
    PAUSE = 1'b0;
  endtask

  // From 00:00 with the adjust divider idle: minutes first, then seconds.
  task automatic adjust_to(input int unsigned mm, input int unsigned ss);
    ADJ = 1'b1;
    SEL = 1'b1;
    cyc(ADJ_DIV_TB * mm);
    SEL = 1'b0;
    cyc(ADJ_DIV_TB * ss);
  endtask

  task automatic test_reset();
    do_reset();
    sb.push_back(mk(0, 0, 0, 0, 1'b0));
    sb.push_back(mk(0, 0, 0, 0, 1'b0));
    exp_w = sb.pop_front(); checks++;
    if (obs !== exp_w) begin failures++; $display("FAIL reset got=%h exp=%h", obs, exp_w); end
    cyc(5);
    exp_w = sb.pop_front(); checks++;
    if (obs !== exp_w) begin failures++; $display("FAIL reset_idle got=%h exp=%h", obs, exp_w); end
  endtask

  task automatic test_run_count();
    do_reset();
    sb.push_back(mk(0, 0, 0, 9, 1'b1));
    sb.push_back(mk(0, 0, 1, 0, 1'b1));
    pulse_pause();
    cyc(80);
    exp_w = sb.pop_front(); checks++;
    if (obs !== exp_w) begin failures++; $display("FAIL run80_pre got=%h exp=%h", obs, exp_w); end
    cyc(1);
    exp_w = sb.pop_front(); checks++;
    if (obs !== exp_w) begin failures++; $display("FAIL run80 got=%h exp=%h", obs, exp_w); end
  endtask

  task automatic test_wrap();
    do_reset();
    adjust_to(0, 59);
    ADJ = 1'b0;
    sb.push_back(mk(0, 0, 5, 9, 1'b1));
    sb.push_back(mk(0, 1, 0, 0, 1'b1));
    pulse_pause();
    cyc(8);
    exp_w = sb.pop_front(); checks++;
    if (obs !== exp_w) begin failures++; $display("FAIL wrap59_pre got=%h exp=%h", obs, exp_w); end
    cyc(1);
    exp_w = sb.pop_front(); checks++;
    if (obs !== exp_w) begin failures++; $display("FAIL wrap59_carry got=%h exp=%h", obs, exp_w); end

    do_reset();
    adjust_to(59, 59);
    ADJ = 1'b0;
    sb.push_back(mk(5, 9, 5, 9, 1'b1));
    sb.push_back(mk(0, 0, 0, 0, 1'b1));
    pulse_pause();
    cyc(8);
    exp_w = sb.pop_front(); checks++;
    if (obs !== exp_w) begin failures++; $display("FAIL wrap5959_pre got=%h exp=%h", obs, exp_w); end
    cyc(1);
    exp_w = sb.pop_front(); checks++;
    if (obs !== exp_w) begin failures++; $display("FAIL wrap5959 got=%h exp=%h", obs, exp_w); end
  endtask

  task automatic test_pause_resume();
    do_reset();
    pulse_pause();
    cyc(27);
    pulse_pause();          // 4 cycles into the fourth second
    sb.push_back(mk(0, 0, 0, 3, 1'b0));
    sb.push_back(mk(0, 0, 0, 3, 1'b1));
    sb.push_back(mk(0, 0, 0, 4, 1'b1));
    cyc(100);
    exp_w = sb.pop_front(); checks++;
    if (obs !== exp_w) begin failures++; $display("FAIL paused_hold got=%h exp=%h", obs, exp_w); end
    pulse_pause();
    cyc(4);
    exp_w = sb.pop_front(); checks++;
    if (obs !== exp_w) begin failures++; $display("FAIL resume_partial_pre got=%h exp=%h", obs, exp_w); end
    cyc(1);
    exp_w = sb.pop_front(); checks++;
    if (obs !== exp_w) begin failures++; $display("FAIL resume_partial got=%h exp=%h", obs, exp_w); end
  endtask

  task automatic test_adjust_min();
    int unsigned mm;
    logic        blank;
    do_reset();
    adjust_to(58, 30);
    SEL = 1'b1;
    for (int unsigned k = 1; k <= 14; k++) begin
      cyc(1);
      mm    = (58 + (k - 1) / ADJ_DIV_TB) % 60;
      blank = (((since_rst - 1) >> 1) & 1) == 1;
      sb.push_back(mk(blank ? 15 : mm / 10, blank ? 15 : mm % 10, 3, 0, 1'b0));
      exp_w = sb.pop_front(); checks++;
      if (obs !== exp_w) begin
        failures++;
        $display("FAIL adj_min k=%0d got=%h exp=%h", k, obs, exp_w);
      end
    end
    ADJ = 1'b0;
    sb.push_back(mk(0, 1, 3, 0, 1'b0));
    cyc(1);
    exp_w = sb.pop_front(); checks++;
    if (obs !== exp_w) begin failures++; $display("FAIL adj_exit got=%h exp=%h", obs, exp_w); end
  endtask

  task automatic test_pause_on_tick();
    do_reset();
    pulse_pause();
    cyc(47);
    pulse_pause();          // lands on the edge of the sixth run tick
    sb.push_back(mk(0, 0, 0, 6, 1'b0));
    sb.push_back(mk(0, 0, 0, 6, 1'b0));
    cyc(1);
    exp_w = sb.pop_front(); checks++;
    if (obs !== exp_w) begin failures++; $display("FAIL pause_tick got=%h exp=%h", obs, exp_w); end
    cyc(20);
    exp_w = sb.pop_front(); checks++;
    if (obs !== exp_w) begin failures++; $display("FAIL pause_tick_hold got=%h exp=%h", obs, exp_w); end
  endtask

  task automatic test_reset_mid_adjust();
    do_reset();
    adjust_to(12, 34);
    pulse_pause();          // state goes to run while still adjusting
    RESET = 1'b1;
    cyc(1);
    RESET = 1'b0;
    ADJ = 1'b0;
    sb.push_back(mk(0, 0, 0, 0, 1'b0));
    exp_w = sb.pop_front(); checks++;
    if (obs !== exp_w) begin failures++; $display("FAIL reset_mid got=%h exp=%h", obs, exp_w); end
    for (int unsigned k = 1; k <= 4; k++) begin
      sb.push_back(mk(0, 0, 0, 0, 1'b0));
      cyc(1);
      exp_w = sb.pop_front(); checks++;
      if (obs !== exp_w) begin
        failures++;
        $display("FAIL reset_mid_after k=%0d got=%h exp=%h", k, obs, exp_w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_count();
    test_wrap();
    test_pause_resume();
    test_adjust_min();
    test_pause_on_tick();
    test_reset_mid_adjust();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
